// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Instruction-memory writer. Takes a program image as a byte
//               stream (valid/ready), packs little-endian 32-bit words and
//               writes them to IM word slots 0..N-1, then verifies a trailing
//               XOR checksum. The CPU is held frozen until a good image has
//               been loaded.
//
//               Stream: LEN lo, LEN hi (N words), 4*N data bytes, checksum
//               (XOR of the data bytes only).
//
// Ports       : clk          system clock
//               reset        synchronous, active-low reset
//               start        one-cycle load request (IDLE/DONE/ERR only)
//               rx_valid     byte valid
//               rx_data      byte data
//               rx_ready     loader can accept a byte
//               im_we        IM write strobe, one cycle per word
//               im_waddr     IM word index being written
//               im_wdata     IM word being written
//               busy         load in progress
//               done         sticky: last load succeeded
//               err          sticky: last load failed
//               cpu_hold     freeze request to the fetch unit
//               load_end_pc  first PC past the loaded image
//
// Revision    : 1.0 - initial release
// ============================================================================
module im_loader #(
    parameter int          ADDR_W  = 12,
    parameter logic [31:0] BASE_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold,
    output logic [31:0]       load_end_pc
);

    localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t              r_state;
    logic [15:0]         r_len;        // word count N
    logic [ADDR_W:0]     r_word_idx;   // one extra bit so N = 2^ADDR_W is reachable
    logic [1:0]          r_byte_cnt;   // byte position inside the current word
    logic [23:0]         r_buf;        // lower three bytes of the word in flight
    logic [7:0]          r_chk;        // running XOR of data bytes

    logic                w_accept;
    logic [15:0]         w_len_full;
    logic [ADDR_W:0]     w_next_idx;

    // rx_ready is a pure decode of the state register.
    assign rx_ready   = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                        (r_state == S_DATA) || (r_state == S_CHK);
    assign w_accept   = rx_valid && rx_ready;
    assign w_len_full = {rx_data, r_len[7:0]};
    assign w_next_idx = r_word_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_word_idx  <= '0;
            r_byte_cnt  <= '0;
            r_buf       <= '0;
            r_chk       <= '0;
            im_we       <= 1'b0;
            im_waddr    <= '0;
            im_wdata    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cpu_hold    <= 1'b1;
            load_end_pc <= BASE_PC;
        end else begin
            // Write strobe lasts exactly one cycle after the 4th byte.
            im_we <= 1'b0;

            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state    <= S_LEN0;
                        r_word_idx <= '0;
                        r_byte_cnt <= '0;
                        r_chk      <= '0;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        cpu_hold   <= 1'b1;
                    end
                end

                S_LEN0: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        r_state    <= S_LEN1;
                    end
                end

                S_LEN1: begin
                    if (w_accept) begin
                        r_len[15:8] <= rx_data;
                        if (32'(w_len_full) > MAX_WORDS) begin
                            r_state <= S_ERR;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                        end else if (w_len_full == 16'd0) begin
                            r_state <= S_CHK;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (w_accept) begin
                        r_chk      <= r_chk ^ rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_byte_cnt)
                            2'd0: r_buf[7:0]   <= rx_data;
                            2'd1: r_buf[15:8]  <= rx_data;
                            2'd2: r_buf[23:16] <= rx_data;
                            default: begin
                                im_we      <= 1'b1;
                                im_waddr   <= r_word_idx[ADDR_W-1:0];
                                im_wdata   <= {rx_data, r_buf};
                                r_word_idx <= w_next_idx;
                                // N was bounded to 2^ADDR_W, so its low
                                // ADDR_W+1 bits hold it exactly.
                                if (w_next_idx == r_len[ADDR_W:0]) begin
                                    r_state <= S_CHK;
                                end
                            end
                        endcase
                    end
                end

                S_CHK: begin
                    if (w_accept) begin
                        busy <= 1'b0;
                        if (rx_data == r_chk) begin
                            r_state     <= S_DONE;
                            done        <= 1'b1;
                            cpu_hold    <= 1'b0;
                            load_end_pc <= BASE_PC + (32'(r_len) << 2);
                        end else begin
                            r_state <= S_ERR;
                            err     <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_loader
// Description : Directed, scoreboard-based bench for im_loader. Expected IM
//               writes are queued as bytes are driven and popped when im_we
//               is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_loader;

    localparam int ADDR_W = 12;

    logic              clk      = 1'b0;
    logic              reset    = 1'b0;
    logic              start    = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;
    logic [31:0]       load_end_pc;

    im_loader #(
        .ADDR_W  (ADDR_W),
        .BASE_PC (32'h0000_3000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .im_we       (im_we),
        .im_waddr    (im_waddr),
        .im_wdata    (im_wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cpu_hold    (cpu_hold),
        .load_end_pc (load_end_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    wr_t         sb[$];
    logic [31:0] img[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        wr_t e;
        if (im_we === 1'b1) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_write observed=%h:%h expected=none", im_waddr, im_wdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_addr", 32'(im_waddr), 32'(e.a));
                check("wr_data", im_wdata, e.d);
            end
        end
    end

    // Present one byte until it is taken; optionally pulse start alongside.
    task automatic send_byte(input logic [7:0] b, input bit thr, input bit pulse_start);
        bit taken = 1'b0;
        bit first = 1'b1;
        int guard = 0;
        while (!taken && guard < 200) begin
            @(negedge clk);
            start    = pulse_start && first;
            first    = 1'b0;
            rx_data  = b;
            rx_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            taken    = rx_valid && rx_ready;
            guard++;
        end
        check("byte_accept", {31'b0, taken}, 32'd1);
    endtask

    task automatic end_stream();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic pulse_start_only();
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
    endtask

    // Full load of img[]; chk_flip corrupts the checksum, start_at marks the
    // data byte at which a (to-be-ignored) start pulse is driven.
    task automatic run_load(input bit thr, input logic [7:0] chk_flip, input int start_at);
        logic [7:0]  c = 8'h00;
        logic [7:0]  b;
        logic [31:0] w;
        int          n = img.size();
        wr_t         e;
        pulse_start_only();
        send_byte(n[7:0], thr, 1'b0);
        send_byte(n[15:8], thr, 1'b0);
        for (int i = 0; i < n; i++) begin
            w   = img[i];
            e.a = i[ADDR_W-1:0];
            e.d = w;
            sb.push_back(e);
            for (int k = 0; k < 4; k++) begin
                b = w[8*k +: 8];
                c = c ^ b;
                send_byte(b, thr, (i * 4 + k) == start_at);
            end
        end
        send_byte(c ^ chk_flip, thr, 1'b0);
        end_stream();
    endtask

    initial begin
        logic [31:0] v;

        // Reset values
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        check("rst_im_we",    {31'b0, im_we},    32'd0);
        check("rst_busy",     {31'b0, busy},     32'd0);
        check("rst_done",     {31'b0, done},     32'd0);
        check("rst_err",      {31'b0, err},      32'd0);
        check("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("rst_end_pc",   load_end_pc,       32'h0000_3000);
        reset = 1'b1;
        @(negedge clk);

        // Good two-word load
        img = '{32'h1234_5678, 32'hDEAD_BEEF};
        run_load(1'b0, 8'h00, -1);
        check("good_done",     {31'b0, done},     32'd1);
        check("good_err",      {31'b0, err},      32'd0);
        check("good_busy",     {31'b0, busy},     32'd0);
        check("good_cpu_hold", {31'b0, cpu_hold}, 32'd0);
        check("good_end_pc",   load_end_pc,       32'h0000_3008);
        check("good_rx_ready", {31'b0, rx_ready}, 32'd0);
        check("good_sb_empty", sb.size(),         32'd0);

        // Bad checksum
        run_load(1'b0, 8'h01, -1);
        check("badchk_err",      {31'b0, err},      32'd1);
        check("badchk_done",     {31'b0, done},     32'd0);
        check("badchk_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("badchk_busy",     {31'b0, busy},     32'd0);
        check("badchk_sb_empty", sb.size(),         32'd0);

        // Throttled stream
        run_load(1'b1, 8'h00, -1);
        check("thr_done",     {31'b0, done}, 32'd1);
        check("thr_end_pc",   load_end_pc,   32'h0000_3008);
        check("thr_sb_empty", sb.size(),     32'd0);

        // N = 0
        img.delete();
        run_load(1'b0, 8'h00, -1);
        check("n0_done",   {31'b0, done}, 32'd1);
        check("n0_end_pc", load_end_pc,   32'h0000_3000);

        // N = 0x1001: rejected right after the count
        pulse_start_only();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h10, 1'b0, 1'b0);
        end_stream();
        check("ovf_err",      {31'b0, err},      32'd1);
        check("ovf_rx_ready", {31'b0, rx_ready}, 32'd0);
        check("ovf_busy",     {31'b0, busy},     32'd0);
        check("ovf_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("ovf_done",     {31'b0, done},     32'd0);

        // N = 0x1000: fills the whole IM
        img.delete();
        for (int i = 0; i < 4096; i++) begin
            v = (i * 32'h9E37_79B9) ^ i;
            img.push_back(v);
        end
        run_load(1'b0, 8'h00, -1);
        check("full_done",     {31'b0, done}, 32'd1);
        check("full_end_pc",   load_end_pc,   32'h0000_7000);
        check("full_sb_empty", sb.size(),     32'd0);

        // Abort after five data bytes
        img = '{32'h1234_5678, 32'hDEAD_BEEF};
        pulse_start_only();
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        sb.push_back('{a: '0, d: 32'h1234_5678});
        send_byte(8'h78, 1'b0, 1'b0);
        send_byte(8'h56, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b0);
        send_byte(8'hEF, 1'b0, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        check("abort_busy",     {31'b0, busy},     32'd0);
        check("abort_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("abort_done",     {31'b0, done},     32'd0);
        check("abort_rx_ready", {31'b0, rx_ready}, 32'd0);
        check("abort_sb_empty", sb.size(),         32'd0);

        // Restart with a stray start pulse mid-load
        run_load(1'b0, 8'h00, 5);
        check("restart_done",     {31'b0, done},     32'd1);
        check("restart_err",      {31'b0, err},      32'd0);
        check("restart_cpu_hold", {31'b0, cpu_hold}, 32'd0);
        check("restart_end_pc",   load_end_pc,       32'h0000_3008);
        check("restart_sb_empty", sb.size(),         32'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
